// File: rtl/btb_update_unit.sv
// btb_update_unit: turns resolved branches into front-end flushes and queued BTB writes.
// Optional statistics counters are built only when BTB_UPD_STATS_EN is defined.
module btb_update_unit #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        res_valid,
    output logic        res_ready,
    input  logic [31:0] res_pc,
    input  logic        res_taken,
    input  logic [31:0] res_target,
    input  logic [1:0]  res_type,
    input  logic        res_pred_hit,
    input  logic [31:0] res_pred_BTA,
    output logic        update_en,
    input  logic        update_ready,
    output logic [31:0] update_pc,
    output logic [31:0] update_BTA,
    output logic [1:0]  update_type,
    output logic        flush,
    output logic [31:0] flush_pc,
    output logic [15:0] stat_mispredict,
    output logic [15:0] stat_update
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] bta;
        logic [1:0]  btype;
    } entry_t;

    entry_t             ent_q [DEPTH];
    entry_t             ent_d [DEPTH];
    entry_t             new_ent;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   tail_idx;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               flush_q, flush_d;
    logic [31:0]        flush_pc_q, flush_pc_d;
    logic               need_update, mispredict, accept, pop, push, overwrite, coalesce;

    assign res_ready   = (count_q < CNT_W'(DEPTH));
    assign update_en   = (count_q != '0);
    assign update_pc   = ent_q[rd_ptr_q].pc;
    assign update_BTA  = ent_q[rd_ptr_q].bta;
    assign update_type = ent_q[rd_ptr_q].btype;
    assign flush       = flush_q;
    assign flush_pc    = flush_pc_q;

    // Classify the resolution, decide push/coalesce/pop and compute next queue state
    always_comb begin
        need_update = res_taken & (~res_pred_hit | (res_pred_BTA != res_target));
        mispredict  = need_update | (~res_taken & res_pred_hit);
        accept      = res_valid & res_ready;
        pop         = update_en & update_ready;
        tail_idx    = wr_ptr_q - PTR_W'(1);
        // The tail cannot be merged into if it is the entry leaving this cycle
        coalesce    = (count_q != '0) & ~(pop & (count_q == CNT_W'(1)))
                    & (ent_q[tail_idx].pc == res_pc);
        push        = accept & need_update & ~coalesce;
        overwrite   = accept & need_update & coalesce;
        new_ent     = '{pc: res_pc, bta: res_target, btype: res_type};

        ent_d = ent_q;
        if (push)      ent_d[wr_ptr_q] = new_ent;
        if (overwrite) ent_d[tail_idx] = new_ent;

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);

        flush_d    = accept & mispredict;
        flush_pc_d = flush_pc_q;
        if (accept && mispredict)
            flush_pc_d = res_taken ? res_target : res_pc + 32'd4;
    end

    // Control state: pointers, occupancy and the one-cycle flush pulse
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            flush_q    <= 1'b0;
            flush_pc_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            flush_q    <= flush_d;
            flush_pc_q <= flush_pc_d;
        end
    end

    // Entry storage; validity is tracked by count, so no reset is needed
    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

`ifdef BTB_UPD_STATS_EN
    logic [15:0] stat_mis_q, stat_mis_d;
    logic [15:0] stat_upd_q, stat_upd_d;

    // Saturating event counters
    always_comb begin
        stat_mis_d = stat_mis_q;
        stat_upd_d = stat_upd_q;
        if (accept && mispredict && stat_mis_q != 16'hFFFF) stat_mis_d = stat_mis_q + 16'd1;
        if (pop && stat_upd_q != 16'hFFFF)                  stat_upd_d = stat_upd_q + 16'd1;
    end

    // Counter registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_mis_q <= '0;
            stat_upd_q <= '0;
        end else begin
            stat_mis_q <= stat_mis_d;
            stat_upd_q <= stat_upd_d;
        end
    end

    assign stat_mispredict = stat_mis_q;
    assign stat_update     = stat_upd_q;
`else
    assign stat_mispredict = 16'd0;
    assign stat_update     = 16'd0;
`endif

endmodule
